// File: rtl/fm_discr_pkg.sv
// Shared widths and FSM state type for the FM phase discriminator.
package fm_discr_pkg;

  localparam int ANGLE_W = 32;
  localparam int ABS_W   = 31;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

endpackage

// File: rtl/fm_phase_discr.sv
// FM phase discriminator: averages 2^DEC_LOG2 successive CORDIC phase steps
// per output, with magnitude squelch.
// Optional build macro: FM_PHASE_DISCR_ROUND_EN (round half up before the
// final shift; otherwise the shift truncates toward minus infinity).
module fm_phase_discr
  import fm_discr_pkg::*;
#(
  parameter int DEC_LOG2 = 4,
  parameter int ACC_W    = 32 + DEC_LOG2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [ANGLE_W-1:0] angle,
  input  logic        [ABS_W-1:0]   abs,
  input  logic        [ABS_W-1:0]   abs_thresh,
  output logic signed [ANGLE_W-1:0] freq,
  output logic                      out_valid,
  output logic                      squelch
);

  if (ACC_W < ANGLE_W + DEC_LOG2) begin : g_acc_w_chk
    $error("fm_phase_discr: ACC_W must be at least 32+DEC_LOG2");
  end

  if (DEC_LOG2 < 0 || DEC_LOG2 > 8) begin : g_dec_chk
    $error("fm_phase_discr: DEC_LOG2 must be in 0..8");
  end

  localparam int CNT_W = DEC_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << DEC_LOG2;

`ifdef FM_PHASE_DISCR_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND =
    (DEC_LOG2 == 0) ? '0 : ACC_W'(1) << ((DEC_LOG2 == 0) ? 0 : DEC_LOG2 - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  state_t                     state, state_nxt;
  logic signed [ANGLE_W-1:0]  prev, prev_nxt;
  logic signed [ACC_W-1:0]    acc, acc_nxt;
  logic        [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
  logic signed [ANGLE_W-1:0]  freq_nxt, freq_blk, d;
  logic signed [ACC_W-1:0]    acc_sum, acc_rnd;
  logic                       ov_nxt, sq_nxt;

  // Next-state, datapath and output decisions for each accepted sample
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    freq_nxt  = freq;
    ov_nxt    = 1'b0;
    sq_nxt    = squelch;

    // Modulo-2^32 difference read as signed gives the short-path phase step
    d        = angle - prev;
    acc_sum  = acc + ACC_W'(d);
    acc_rnd  = acc_sum + RND;
    freq_blk = ANGLE_W'(acc_rnd >>> DEC_LOG2);
    cnt_inc  = cnt + CNT_W'(1);

    if (in_valid) begin
      if (abs < abs_thresh) begin
        state_nxt = PRIME;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        sq_nxt    = 1'b1;
      end else begin
        sq_nxt   = 1'b0;
        prev_nxt = angle;
        case (state)
          PRIME: begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = RUN;
          end
          RUN: begin
            if (cnt_inc == CNT_FULL) begin
              freq_nxt = freq_blk;
              ov_nxt   = 1'b1;
              acc_nxt  = '0;
              cnt_nxt  = '0;
            end else begin
              acc_nxt  = acc_sum;
              cnt_nxt  = cnt_inc;
            end
          end
          default: state_nxt = PRIME;
        endcase
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= PRIME;
      prev      <= '0;
      acc       <= '0;
      cnt       <= '0;
      freq      <= '0;
      out_valid <= 1'b0;
      squelch   <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      freq      <= freq_nxt;
      out_valid <= ov_nxt;
      squelch   <= sq_nxt;
    end
  end

endmodule

// File: doc/fm_phase_discr.md
FM_PHASE_DISCR -- requirements
Module: fm_phase_discr

Interface
REQ-001 SHALL have parameter DEC_LOG2, default 4, meaning log2 of the number of phase differences averaged per output (legal range 0..8).
REQ-002 SHALL have parameter ACC_W, default 32+DEC_LOG2, meaning accumulator width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: angle/abs are a new sample this cycle.
REQ-006 SHALL have port angle, input, signed 32 bits: CORDIC phase; full scale 2^32 = 360 deg.
REQ-007 SHALL have port abs, input, unsigned 31 bits: CORDIC magnitude.
REQ-008 SHALL have port abs_thresh, input, unsigned 31 bits: squelch threshold, quasi-static.
REQ-009 SHALL have port freq, output, signed 32 bits: averaged phase step per sample.
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle pulse, freq is new.
REQ-011 SHALL have port squelch, output, 1 bit: last accepted sample was below threshold.

Function
REQ-012 SHALL sample inputs only in cycles with in_valid=1; cycles with in_valid=0 change no state, and freq holds its value.
REQ-013 SHALL implement a two-state FSM: PRIME (no previous angle held) and RUN.
REQ-014 In PRIME, a valid sample with abs >= abs_thresh SHALL store angle into prev, clear acc and cnt, and move to RUN; no difference is produced.
REQ-015 In RUN, a valid sample with abs >= abs_thresh SHALL compute d = angle - prev modulo 2^32, interpreted as signed 32 bits, so that wrap through +/-180 deg gives the short-path step. It SHALL add sign-extended d to acc, store angle into prev, and increment cnt.
REQ-016 When cnt reaches 2^DEC_LOG2 after an increment, the block SHALL register freq = acc_total >>> DEC_LOG2 (arithmetic shift, lower 32 bits), where acc_total includes the current d. It SHALL pulse out_valid in the next cycle and restart the next block with acc=0 and cnt=0.
REQ-017 A valid sample with abs < abs_thresh SHALL discard the partial acc and cnt, set squelch=1, and enter PRIME. freq SHALL be unchanged and no out_valid pulse is produced.
REQ-018 squelch SHALL clear on the next valid sample with abs >= abs_thresh.
REQ-019 Latency SHALL be one clock from the valid sample that completes a block to out_valid=1.
REQ-020 The accumulator SHALL not overflow: ACC_W >= 32+DEC_LOG2 is required, checked by an elaboration-time assertion.
REQ-021 With DEC_LOG2=0, every RUN sample SHALL produce out_valid with freq=d.

Reset
REQ-022 On clk rising edge with rst_n=0: state=PRIME, prev=0, acc=0, cnt=0, freq=0, out_valid=0, squelch=0.
REQ-023 Reset asserted mid-block SHALL discard the partial block; no out_valid pulse follows the reset.

Configuration
REQ-024 Macro FM_PHASE_DISCR_ROUND_EN:
- When defined, the block SHALL add 2^(DEC_LOG2-1) to acc_total before the shift (round half up); with DEC_LOG2=0 nothing is added.
- When undefined, the block SHALL truncate toward minus infinity.

Structure
REQ-025 Package fm_discr_pkg SHALL hold ANGLE_W=32, ABS_W=31, and the state enum typedef (PRIME, RUN).
REQ-026 The block SHALL be a single module; no sub-module is required.

Verification
REQ-027 Use DEC_LOG2=4 and abs=1000, thresh=10. Angle ramps 0, 0x0100_0000, 0x0200_0000, ... continuously valid -> first out_valid one cycle after the 17th sample, freq=0x0100_0000, then every 16 samples.
REQ-028 Wrap: DEC_LOG2=0, angle 0x7F00_0000 then 0x8100_0000 -> freq=0x0200_0000 (positive); reverse order -> freq=0xFE00_0000.
REQ-029 Squelch: ramp as in REQ-027, with abs=5 on sample 9 -> squelch=1, no output; then abs=1000 -> squelch=0, first output 17 valid samples after the squelched one.
REQ-030 Gaps: REQ-027 stimulus with in_valid toggling 1/0 -> identical freq values; out_valid only on the cycle after the completing sample.
REQ-031 Reset: rst_n=0 for 1 cycle after sample 10 -> all outputs 0; no pulse until 17 further samples.
REQ-032 Rounding: DEC_LOG2=1, d = 1 and 2 -> freq=2 with FM_PHASE_DISCR_ROUND_EN defined, 1 without it; d = -1 and -2 -> -1 defined, -2 undefined.
